// File: rtl/seg_scan_if.sv
// Multiplexed seven-segment scan bus plus the decoder's status outputs.
interface seg_scan_if;
  logic [7:0]  seg_in;
  logic [3:0]  an_in;
  logic [19:0] codes;
  logic        frame_valid;
  logic        stable;
  logic        scan_lost;
  logic        bad_an;

  modport master (
    output seg_in, an_in,
    input  codes, frame_valid, stable, scan_lost, bad_an
  );

  modport slave (
    input  seg_in, an_in,
    output codes, frame_valid, stable, scan_lost, bad_an
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed seven-segment display: samples {seg, an},
// waits for the bus to settle, decodes each digit into a glyph code,
// assembles four-digit frames and tracks frame stability and scan loss.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic       clk,
  input logic       reset,
  seg_scan_if.slave scan
);

  localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int MATCH_W = $clog2(STABLE_FRAMES + 1);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLING, ST_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [11:0]        bus_now, bus_p0;
  logic               onehot, bad_pat, bus_same;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               capture;
  logic [4:0]         slot_q [4];
  logic [3:0]         seen_q;
  logic [19:0]        codes_q, frame_codes;
  logic               frame_fire;
  logic [MATCH_W-1:0] match_q;
  logic [19:0]        idle_q;
  logic               timeout_hit;
  logic               fv_q, lost_q, bad_q;

  // Exact-match glyph table; anything unrecognised maps to 31.
  function automatic logic [4:0] glyph(input logic [7:0] p);
    case (p)
      8'b01111110: glyph = 5'd0;
      8'b00110000: glyph = 5'd1;
      8'b01101101: glyph = 5'd2;
      8'b01111001: glyph = 5'd3;
      8'b00110011: glyph = 5'd4;
      8'b01011011: glyph = 5'd5;
      8'b01011111: glyph = 5'd6;
      8'b01110000: glyph = 5'd7;
      8'b01111111: glyph = 5'd8;
      8'b01111011: glyph = 5'd9;
      8'b01001001: glyph = 5'd10;
      8'b00001111: glyph = 5'd11;
      8'b01110111: glyph = 5'd12;
      8'b01000110: glyph = 5'd13;
      8'b00011111: glyph = 5'd14;
      8'b00111101: glyph = 5'd15;
      8'b00111011: glyph = 5'd16;
      8'b00001101: glyph = 5'd17;
      8'b01001111: glyph = 5'd18;
      8'b00000000: glyph = 5'd30;
      default:     glyph = 5'd31;
    endcase
  endfunction

  assign bus_now     = {scan.seg_in, scan.an_in};
  assign onehot      = (scan.an_in != 4'd0) && ((scan.an_in & (scan.an_in - 4'd1)) == 4'd0);
  assign bad_pat     = (scan.an_in != 4'd0) && !onehot;
  assign bus_same    = (bus_now == bus_p0);
  assign frame_fire  = (seen_q == 4'hf);
  assign frame_codes = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
  // A frame completing in the same cycle takes precedence over the timeout.
  assign timeout_hit = (idle_q == 20'(TIMEOUT_CYCLES - 1)) && !capture && !frame_fire;

  // Capture fires on the edge where the settle count would reach SETTLE_CYCLES-1,
  // so a digit is written SETTLE_CYCLES edges after the bus last changed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_WAIT: begin
        cnt_d = '0;
        if (onehot) state_d = ST_SETTLING;
      end
      ST_SETTLING: begin
        if (!onehot) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (!bus_same) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 2)) begin
          capture = 1'b1;
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        cnt_d = '0;
        if (!bus_same) state_d = onehot ? ST_SETTLING : ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Previous-cycle bus sample used for change detection.
  always_ff @(posedge clk) begin
    bus_p0 <= bus_now;
  end

  // Digit slot registers; partial frames are discarded by clearing seen, not slots.
  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      for (int i = 0; i < 4; i++) begin
        if (scan.an_in[i]) slot_q[i] <= glyph(scan.seg_in);
      end
    end
  end

  // FSM state, frame assembly, stability, timeout and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      seen_q  <= '0;
      codes_q <= '0;
      fv_q    <= 1'b0;
      match_q <= '0;
      idle_q  <= '0;
      lost_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= frame_fire;
      if (bad_pat) bad_q <= 1'b1;

      if (timeout_hit) seen_q <= '0;
      else             seen_q <= (frame_fire ? 4'd0 : seen_q) | (capture ? scan.an_in : 4'd0);

      if (frame_fire) begin
        codes_q <= frame_codes;
        if (match_q == '0 || frame_codes != codes_q) match_q <= MATCH_W'(1);
        else if (match_q < MATCH_W'(STABLE_FRAMES))  match_q <= match_q + MATCH_W'(1);
      end else if (timeout_hit) begin
        match_q <= '0;
      end

      if (capture || frame_fire)                    idle_q <= '0;
      else if (idle_q < 20'(TIMEOUT_CYCLES - 1))    idle_q <= idle_q + 20'd1;

      if (capture)          lost_q <= 1'b0;
      else if (timeout_hit) lost_q <= 1'b1;
    end
  end

  assign scan.codes       = codes_q;
  assign scan.frame_valid = fv_q;
  assign scan.stable      = (match_q >= MATCH_W'(STABLE_FRAMES));
  assign scan.scan_lost   = lost_q;
  assign scan.bad_an      = bad_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: expected frames are queued as the
// stimulus is issued and a monitor checks every frame_valid pulse.
module tb_seg_scan_decoder;

  localparam int TO = 2000;

  localparam logic [7:0] G_S = 8'b01001001;
  localparam logic [7:0] G_T = 8'b00001111;
  localparam logic [7:0] G_A = 8'b01110111;
  localparam logic [7:0] G_R = 8'b01000110;
  localparam logic [7:0] G_B = 8'b00011111;
  localparam logic [7:0] G_D = 8'b00111101;
  localparam logic [7:0] G_Y = 8'b00111011;
  localparam logic [7:0] G_E = 8'b01001111;
  localparam logic [7:0] G_8 = 8'b01111111;

  localparam logic [19:0] C_STAR = {5'd13, 5'd12, 5'd11, 5'd10};
  localparam logic [19:0] C_BDAY = {5'd16, 5'd12, 5'd15, 5'd14};
  localparam logic [19:0] C_YEAR = {5'd13, 5'd12, 5'd18, 5'd16};

  typedef struct packed {
    logic [19:0] codes;
    logic        stable;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   fv_idx;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  seg_scan_if scan();

  seg_scan_decoder #(
    .SETTLE_CYCLES(16),
    .STABLE_FRAMES(3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .scan(scan)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Present one bus value for n cycles; remembers when frame_valid first appears.
  task automatic drive(input logic [7:0] seg, input logic [3:0] an, input int n);
    @(negedge clk);
    scan.seg_in = seg;
    scan.an_in  = an;
    fv_idx = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (scan.frame_valid && fv_idx == 0) fv_idx = i;
    end
  endtask

  task automatic scan_word(input logic [7:0] g0, input logic [7:0] g1,
                           input logic [7:0] g2, input logic [7:0] g3,
                           input logic check_lat);
    drive(g0, 4'b0001, 200);
    drive(g1, 4'b0010, 200);
    drive(g2, 4'b0100, 200);
    drive(g3, 4'b1000, 200);
    if (check_lat) chk("frame_latency", fv_idx, 17);
  endtask

  task automatic push(input logic [19:0] c, input logic s);
    exp_t e;
    e.codes  = c;
    e.stable = s;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_codes"}, scan.codes, 0);
    chk({tag, "_fv"}, scan.frame_valid, 0);
    chk({tag, "_stable"}, scan.stable, 0);
    chk({tag, "_lost"}, scan.scan_lost, 0);
    chk({tag, "_bad_an"}, scan.bad_an, 0);
  endtask

  // Monitor: every frame_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && scan.frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got codes %0h required no frame", scan.codes);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_codes", scan.codes, e.codes);
        chk("frame_stable", scan.stable, e.stable);
      end
    end
  end

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    scan.seg_in = 8'h00;
    scan.an_in  = 4'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Three identical "star" frames: stable on the third.
    push(C_STAR, 1'b0); scan_word(G_S, G_T, G_A, G_R, 1'b1);
    push(C_STAR, 1'b0); scan_word(G_S, G_T, G_A, G_R, 1'b0);
    push(C_STAR, 1'b1); scan_word(G_S, G_T, G_A, G_R, 1'b0);

    // Glitches inside digit1's settle window, then clean final pattern.
    push(C_STAR, 1'b1);
    drive(G_S, 4'b0001, 200);
    drive(G_8, 4'b0010, 12);
    for (int i = 1; i <= 5; i++) drive(8'(i), 4'b0010, 1);
    drive(G_T, 4'b0010, 200);
    drive(G_A, 4'b0100, 200);
    drive(G_R, 4'b1000, 200);
    chk("glitch_latency", fv_idx, 17);

    // "bday" then "year": stability restarts on the change of content.
    push(C_BDAY, 1'b0); scan_word(G_B, G_D, G_A, G_Y, 1'b0);
    push(C_BDAY, 1'b0); scan_word(G_B, G_D, G_A, G_Y, 1'b0);
    push(C_BDAY, 1'b1); scan_word(G_B, G_D, G_A, G_Y, 1'b0);
    push(C_YEAR, 1'b0); scan_word(G_Y, G_E, G_A, G_R, 1'b0);
    push(C_YEAR, 1'b0); scan_word(G_Y, G_E, G_A, G_R, 1'b0);
    push(C_YEAR, 1'b1); scan_word(G_Y, G_E, G_A, G_R, 1'b0);
    chk("bad_an_clean", scan.bad_an, 0);

    // Non-one-hot enable: sticky flag, cleared only by reset.
    drive(G_S, 4'b0110, 1);
    drive(8'h00, 4'b0000, 20);
    chk("bad_an_set", scan.bad_an, 1);
    drive(8'h00, 4'b0000, 30);
    chk("bad_an_sticky", scan.bad_an, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("reset2");

    // Scan loss: build stability, stop scanning, then resume.
    push(C_STAR, 1'b0); scan_word(G_S, G_T, G_A, G_R, 1'b0);
    push(C_STAR, 1'b0); scan_word(G_S, G_T, G_A, G_R, 1'b0);
    push(C_STAR, 1'b1); scan_word(G_S, G_T, G_A, G_R, 1'b0);
    chk("lost_before", scan.scan_lost, 0);
    drive(8'h00, 4'b0000, TO + 100);
    chk("lost_set", scan.scan_lost, 1);
    chk("lost_stable", scan.stable, 0);
    chk("lost_codes_hold", scan.codes, C_STAR);
    push(C_STAR, 1'b0);
    drive(G_S, 4'b0001, 5);
    chk("lost_until_capture", scan.scan_lost, 1);
    drive(G_S, 4'b0001, 195);
    chk("lost_cleared", scan.scan_lost, 0);
    drive(G_T, 4'b0010, 200);
    drive(G_A, 4'b0100, 200);
    drive(G_R, 4'b1000, 200);

    // Reset after two captures discards them; next full scan gives one frame.
    drive(G_S, 4'b0001, 200);
    drive(G_T, 4'b0010, 200);
    @(negedge clk);
    reset = 1'b1;
    scan.an_in = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("reset3");
    drive(G_A, 4'b0100, 200);
    drive(G_R, 4'b1000, 200);
    push(C_STAR, 1'b0);
    drive(G_S, 4'b0001, 200);
    drive(G_T, 4'b0010, 200);
    drive(8'h00, 4'b0000, 20);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
